interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Owns the CPU interrupt state: the NMI pending latch (TNMI), IFF1/IFF2 and the interrupt mode (IM).
- At every instruction boundary it arbitrates NMI against maskable INT. It then runs the acknowledge, stack-push and vector-fetch handshakes with the core.
- Result is a jump target or, in IM0, an injected opcode.
- Sits between the external interrupt pins and the core's fetch/sequencing logic; the core stalls fetch while Busy=1.

Parameters:
NMI_VEC, 16'h0066, NMI jump target
IM1_VEC, 16'h0038, IM1 jump target
INT_ACK_CYCLES, 2, length of the INT acknowledge phase in cycles (>=1)

Ports:
Clk  in  1  sole clock, all state rises on posedge
Reset  in  1  asynchronous, active-high; clears all state
NMI  in  1  NMI request, rising edge sensitive, already synchronous to Clk
INT  in  1  maskable request, level, active-high
InstrEnd  in  1  current instruction completes this cycle; sole acceptance point
OpEI  in  1  EI executed (strobe)
OpDI  in  1  DI executed (strobe)
OpRETN  in  1  RETN executed (strobe)
OpIM  in  1  IM n executed (strobe)
ImVal  in  2  opcode bits 4:3 of IM n: 00/01 -> IM0, 10 -> IM1, 11 -> IM2
IReg  in  8  I register
DataBus  in  8  byte supplied by the device during INT acknowledge
PushDone  in  1  core finished pushing PC
VecRdDone  in  1  core finished the 16-bit vector read
VecRdData  in  16  vector read result
TNMI  out  1  NMI pending
IFF1  out  1  interrupt enable flip-flop 1
IFF2  out  1  interrupt enable flip-flop 2 (readable via LD A,I/R)
IM  out  2  current mode: 0, 1 or 2
Busy  out  1  sequencer not IDLE
IntAck  out  1  INT acknowledge phase active
PushReq  out  1  request PC push, held until PushDone
VecRdReq  out  1  request vector read, held until VecRdDone
VecRdAddr  out  16  {IReg, DataBus[7:1], 1'b0}, latched at ack
JumpValid  out  1  one-cycle pulse, JumpAddr valid
JumpAddr  out  16  jump target
InjectValid  out  1  one-cycle pulse, IM0 opcode valid
InjectOp  out  8  IM0 opcode (acked DataBus byte)

Behaviour:
- Reset (async): state IDLE; every output 0; IM=0; the NMI edge-history register is cleared. Reset asserted mid-sequence aborts the sequence with no further pulses.
- NMI edge: a registered previous sample gives `nmi_rise = NMI & ~prev`, which sets TNMI on the next edge. TNMI clears when the sequencer enters NMI_ACK. If a rise and the clear land in the same cycle, set wins.
- Acceptance, only in IDLE with InstrEnd=1 (InstrEnd is ignored while Busy):
  - If TNMI=1, go to NMI_ACK. Update IFF1<=0; IFF2 keeps its prior value, or takes the EI/DI/RETN result if one of those strobes is active this cycle.
  - Else if INT & IFF1 & ~OpEI & ~OpDI, go to INT_ACK with IFF1<=0 and IFF2<=0.
  - Otherwise stay IDLE.
- EI therefore never admits INT at its own boundary; INT is admitted at the next boundary.
- Strobes, applied whenever asserted unless overridden by an acceptance:
  - OpEI: IFF1=IFF2=1.
  - OpDI: both 0.
  - OpRETN: IFF1<=IFF2.
  - OpIM: IM<=ImVal mapping.
- States:
  - NMI_ACK: 1 cycle -> PUSH; target NMI_VEC.
  - INT_ACK: IntAck=1 for INT_ACK_CYCLES cycles. DataBus is latched on the last cycle. Then IM0 -> INJECT, IM1 -> PUSH (target IM1_VEC), IM2 -> PUSH (then VEC_RD).
  - PUSH: PushReq=1 until the cycle PushDone=1. Then -> VEC_RD if IM2-INT, else JUMP.
  - VEC_RD: VecRdReq=1, VecRdAddr stable, until VecRdDone=1. VecRdData is latched as target, then -> JUMP.
  - JUMP: JumpValid=1 for one cycle with JumpAddr -> IDLE.
  - INJECT: InjectValid=1 for one cycle with InjectOp=latched byte, no push -> IDLE. The core executes the opcode; if it is RST it pushes on its own.
- IM is sampled at INT acceptance. An OpIM arriving during a sequence does not alter that sequence.
- A new NMI edge arriving during any sequence sets TNMI; it is serviced at the first InstrEnd after return to IDLE.
- PushDone and VecRdDone are ignored outside their states. A Done in the same cycle as the Req rise is legal, giving a 1-cycle phase.

Test Plan:
- After Reset, NMI rise with InstrEnd 2 cycles later -> TNMI=1, then NMI_ACK, PushReq held until PushDone, then JumpValid with JumpAddr=0x0066. Final IFF1=0, IFF2 keeps its pre-NMI value; a subsequent RETN restores IFF1=IFF2.
- IM2, IReg=0x80, EI then INT=1 on the same InstrEnd -> not accepted. At the next InstrEnd -> IntAck for 2 cycles with DataBus=0x35, then VecRdAddr=0x8034. VecRdData=0x1234 -> JumpAddr=0x1234, IFF1=IFF2=0.
- IM1 with NMI and INT both pending at one InstrEnd -> NMI serviced first (JumpAddr 0x0066); INT is not accepted afterwards because IFF1=0.
- IM0, INT accepted, DataBus=0xFF -> InjectValid pulse with InjectOp=0xFF, no PushReq.
- Reset asserted during VEC_RD -> all outputs 0 immediately; no JumpValid after Reset releases.
- NMI rise during PUSH of an INT sequence -> TNMI=1 and held; NMI sequence starts at the first InstrEnd after the INT JumpValid.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: owns NMI/INT pending state, IFF1/IFF2 and IM. Arbitrates
// at instruction boundaries and runs the ack / push / vector-read handshakes
// with the core, finishing in either a jump target or an injected IM0 opcode.
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC        = 16'h0066,
    parameter logic [15:0] IM1_VEC        = 16'h0038,
    parameter int          INT_ACK_CYCLES = 2
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        NMI,
    input  logic        INT,
    input  logic        InstrEnd,
    input  logic        OpEI,
    input  logic        OpDI,
    input  logic        OpRETN,
    input  logic        OpIM,
    input  logic [1:0]  ImVal,
    input  logic [7:0]  IReg,
    input  logic [7:0]  DataBus,
    input  logic        PushDone,
    input  logic        VecRdDone,
    input  logic [15:0] VecRdData,
    output logic        TNMI,
    output logic        IFF1,
    output logic        IFF2,
    output logic [1:0]  IM,
    output logic        Busy,
    output logic        IntAck,
    output logic        PushReq,
    output logic        VecRdReq,
    output logic [15:0] VecRdAddr,
    output logic        JumpValid,
    output logic [15:0] JumpAddr,
    output logic        InjectValid,
    output logic [7:0]  InjectOp
);

    localparam int CW = (INT_ACK_CYCLES > 1) ? $clog2(INT_ACK_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NMI_ACK = 3'd1,
        INT_ACK = 3'd2,
        PUSH    = 3'd3,
        VEC_RD  = 3'd4,
        JUMP    = 3'd5,
        INJECT  = 3'd6
    } seqState_t;

    seqState_t state, nextState;

    logic          nmiPrev;
    logic          nmiRise;
    logic          acceptNmi;
    logic          acceptInt;
    logic [CW-1:0] ackCnt;
    logic          ackLast;
    logic [1:0]    seqMode;   // IM captured when INT was accepted
    logic          seqVecRd;  // this sequence needs the IM2 vector read

    // ImVal is opcode bits 4:3 of IM n; 00 and 01 both select IM0
    function automatic logic [1:0] mapIm(input logic [1:0] v);
        case (v)
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    assign nmiRise   = NMI & ~nmiPrev;
    assign acceptNmi = (state == IDLE) & InstrEnd & TNMI;
    // EI/DI at the same boundary block INT so EI only opens the window next time
    assign acceptInt = (state == IDLE) & InstrEnd & ~TNMI & INT & IFF1 & ~OpEI & ~OpDI;
    assign ackLast   = (ackCnt == CW'(INT_ACK_CYCLES - 1));

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // next-state and handshake outputs, all derived from the current state
    always_comb begin
        nextState   = state;
        Busy        = (state != IDLE);
        IntAck      = 1'b0;
        PushReq     = 1'b0;
        VecRdReq    = 1'b0;
        JumpValid   = 1'b0;
        InjectValid = 1'b0;
        case (state)
            IDLE: begin
                if (acceptNmi)      nextState = NMI_ACK;
                else if (acceptInt) nextState = INT_ACK;
            end
            NMI_ACK: nextState = PUSH;
            INT_ACK: begin
                IntAck = 1'b1;
                if (ackLast) nextState = (seqMode == 2'd0) ? INJECT : PUSH;
            end
            PUSH: begin
                PushReq = 1'b1;
                if (PushDone) nextState = seqVecRd ? VEC_RD : JUMP;
            end
            VEC_RD: begin
                VecRdReq = 1'b1;
                if (VecRdDone) nextState = JUMP;
            end
            JUMP: begin
                JumpValid = 1'b1;
                nextState = IDLE;
            end
            INJECT: begin
                InjectValid = 1'b1;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NMI edge history and pending latch; a fresh rise beats the ack clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nmiPrev <= 1'b0;
            TNMI    <= 1'b0;
        end else begin
            nmiPrev <= NMI;
            if (nmiRise)        TNMI <= 1'b1;
            else if (acceptNmi) TNMI <= 1'b0;
        end
    end

    // IFF1/IFF2: acceptance overrides the EI/DI/RETN strobes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            IFF1 <= 1'b0;
            IFF2 <= 1'b0;
        end else if (acceptNmi) begin
            IFF1 <= 1'b0;
            if (OpEI)      IFF2 <= 1'b1;
            else if (OpDI) IFF2 <= 1'b0;
        end else if (acceptInt) begin
            IFF1 <= 1'b0;
            IFF2 <= 1'b0;
        end else if (OpEI) begin
            IFF1 <= 1'b1;
            IFF2 <= 1'b1;
        end else if (OpDI) begin
            IFF1 <= 1'b0;
            IFF2 <= 1'b0;
        end else if (OpRETN) begin
            IFF1 <= IFF2;
        end
    end

    // interrupt mode; a running sequence uses its own captured copy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     IM <= 2'd0;
        else if (OpIM) IM <= mapIm(ImVal);
    end

    // sequence context: mode, ack counter, device byte, vector address, target
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seqMode   <= 2'd0;
            seqVecRd  <= 1'b0;
            ackCnt    <= '0;
            VecRdAddr <= 16'h0000;
            JumpAddr  <= 16'h0000;
            InjectOp  <= 8'h00;
        end else begin
            if (acceptNmi) begin
                JumpAddr <= NMI_VEC;
                seqVecRd <= 1'b0;
            end
            if (acceptInt) begin
                seqMode  <= IM;
                seqVecRd <= (IM == 2'd2);
                ackCnt   <= '0;
            end
            if (state == INT_ACK) begin
                ackCnt <= ackCnt + CW'(1);
                if (ackLast) begin
                    InjectOp  <= DataBus;
                    VecRdAddr <= {IReg, DataBus[7:1], 1'b0};
                    if (seqMode == 2'd1) JumpAddr <= IM1_VEC;
                end
            end
            if ((state == VEC_RD) && VecRdDone) JumpAddr <= VecRdData;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: strobe table, directed multi-cycle sequences,
// then random traffic against a phase-queue reference model.
module tb_interrupt_sequencer;

    localparam int ACKN = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        NMI, INT, InstrEnd, OpEI, OpDI, OpRETN, OpIM;
    logic [1:0]  ImVal;
    logic [7:0]  IReg, DataBus;
    logic        PushDone, VecRdDone;
    logic [15:0] VecRdData;
    logic        TNMI, IFF1, IFF2, Busy, IntAck, PushReq, VecRdReq, JumpValid, InjectValid;
    logic [1:0]  IM;
    logic [15:0] VecRdAddr, JumpAddr;
    logic [7:0]  InjectOp;

    int errors = 0;
    int checks = 0;

    interrupt_sequencer #(.NMI_VEC(16'h0066), .IM1_VEC(16'h0038), .INT_ACK_CYCLES(ACKN)) dut (
        .Clk(Clk), .Reset(Reset), .NMI(NMI), .INT(INT), .InstrEnd(InstrEnd),
        .OpEI(OpEI), .OpDI(OpDI), .OpRETN(OpRETN), .OpIM(OpIM), .ImVal(ImVal),
        .IReg(IReg), .DataBus(DataBus), .PushDone(PushDone), .VecRdDone(VecRdDone),
        .VecRdData(VecRdData), .TNMI(TNMI), .IFF1(IFF1), .IFF2(IFF2), .IM(IM),
        .Busy(Busy), .IntAck(IntAck), .PushReq(PushReq), .VecRdReq(VecRdReq),
        .VecRdAddr(VecRdAddr), .JumpValid(JumpValid), .JumpAddr(JumpAddr),
        .InjectValid(InjectValid), .InjectOp(InjectOp)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearInputs();
        NMI = 0; INT = 0; InstrEnd = 0; OpEI = 0; OpDI = 0; OpRETN = 0; OpIM = 0;
        ImVal = 0; IReg = 0; DataBus = 0; PushDone = 0; VecRdDone = 0; VecRdData = 0;
    endtask

    // ---------------- reference model ----------------
    localparam int P_NACK = 1, P_IACK = 2, P_PUSH = 3, P_VRD = 4, P_JUMP = 5, P_INJ = 6;
    int          q[$];          // remaining phases of the current sequence
    logic        mPrev, mTnmi, mIff1, mIff2;
    logic [1:0]  mIm;
    logic [15:0] mTarget, mVecAddr;
    logic [7:0]  mInj;

    task automatic modelReset();
        q.delete();
        mPrev = 0; mTnmi = 0; mIff1 = 0; mIff2 = 0; mIm = 0;
        mTarget = 0; mVecAddr = 0; mInj = 0;
    endtask

    function automatic int head();
        return (q.size() != 0) ? q[0] : 0;
    endfunction

    task automatic modelStep();
        logic rise, idle, accN, accI;
        rise = NMI && !mPrev;
        mPrev = NMI;
        idle = (q.size() == 0);
        accN = idle && InstrEnd && mTnmi;
        accI = idle && InstrEnd && !mTnmi && INT && mIff1 && !OpEI && !OpDI;
        if (!idle) begin
            case (q[0])
                P_PUSH: if (PushDone) void'(q.pop_front());
                P_VRD: if (VecRdDone) begin
                    mTarget = VecRdData;
                    void'(q.pop_front());
                end
                P_IACK: begin
                    if (q.size() > 1 && q[1] != P_IACK) begin
                        mVecAddr = {IReg, DataBus[7:1], 1'b0};
                        mInj = DataBus;
                    end
                    void'(q.pop_front());
                end
                default: void'(q.pop_front());
            endcase
        end
        if (accN) begin
            q = '{P_NACK, P_PUSH, P_JUMP};
            mTarget = 16'h0066;
        end else if (accI) begin
            repeat (ACKN) q.push_back(P_IACK);
            if (mIm == 0) q.push_back(P_INJ);
            else if (mIm == 1) begin
                q.push_back(P_PUSH); q.push_back(P_JUMP);
                mTarget = 16'h0038;
            end else begin
                q.push_back(P_PUSH); q.push_back(P_VRD); q.push_back(P_JUMP);
            end
        end
        if (accN) begin
            mIff1 = 0;
            if (OpEI) mIff2 = 1;
            else if (OpDI) mIff2 = 0;
        end else if (accI) begin
            mIff1 = 0; mIff2 = 0;
        end else if (OpEI) begin
            mIff1 = 1; mIff2 = 1;
        end else if (OpDI) begin
            mIff1 = 0; mIff2 = 0;
        end else if (OpRETN) begin
            mIff1 = mIff2;
        end
        if (rise) mTnmi = 1;
        else if (accN) mTnmi = 0;
        if (OpIM) mIm = (ImVal < 2) ? 2'd0 : ImVal - 2'd1;
    endtask

    task automatic modelCompare();
        check("rnd.Busy", Busy, q.size() != 0);
        check("rnd.IntAck", IntAck, head() == P_IACK);
        check("rnd.PushReq", PushReq, head() == P_PUSH);
        check("rnd.VecRdReq", VecRdReq, head() == P_VRD);
        check("rnd.JumpValid", JumpValid, head() == P_JUMP);
        check("rnd.InjectValid", InjectValid, head() == P_INJ);
        check("rnd.TNMI", TNMI, mTnmi);
        check("rnd.IFF1", IFF1, mIff1);
        check("rnd.IFF2", IFF2, mIff2);
        check("rnd.IM", IM, mIm);
        if (head() == P_JUMP) check("rnd.JumpAddr", JumpAddr, mTarget);
        if (head() == P_VRD)  check("rnd.VecRdAddr", VecRdAddr, mVecAddr);
        if (head() == P_INJ)  check("rnd.InjectOp", InjectOp, mInj);
    endtask

    // ---------------- strobe table ----------------
    typedef struct {
        logic       ei, di, retn, imOp;
        logic [1:0] imVal;
        logic       expIff1, expIff2;
        logic [1:0] expIm;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 0, 0, 0, 2'b00, 1, 1, 2'd0};
        vecs[1] = '{0, 0, 0, 1, 2'b10, 1, 1, 2'd1};
        vecs[2] = '{0, 0, 1, 0, 2'b00, 1, 1, 2'd1};
        vecs[3] = '{0, 1, 0, 0, 2'b00, 0, 0, 2'd1};
        vecs[4] = '{0, 0, 0, 1, 2'b11, 0, 0, 2'd2};
        vecs[5] = '{0, 0, 1, 0, 2'b00, 0, 0, 2'd2};
        vecs[6] = '{1, 0, 0, 1, 2'b01, 1, 1, 2'd0};
        vecs[7] = '{0, 0, 0, 1, 2'b11, 1, 1, 2'd2};
        vecs[8] = '{0, 0, 0, 1, 2'b00, 1, 1, 2'd0};
        vecs[9] = '{0, 1, 0, 0, 2'b00, 0, 0, 2'd0};

        clearInputs();
        Reset = 1;
        step(); step();
        check("rst.Busy", Busy, 0);
        check("rst.IFF", {IFF1, IFF2, TNMI}, 0);
        check("rst.IM", IM, 0);
        check("rst.outs", {IntAck, PushReq, VecRdReq, JumpValid, InjectValid}, 0);
        check("rst.data", {VecRdAddr, JumpAddr, InjectOp}, 0);
        Reset = 0;
        step();

        for (int i = 0; i < 10; i++) begin
            OpEI = vecs[i].ei; OpDI = vecs[i].di; OpRETN = vecs[i].retn;
            OpIM = vecs[i].imOp; ImVal = vecs[i].imVal;
            step();
            check($sformatf("tbl[%0d].IFF1", i), IFF1, vecs[i].expIff1);
            check($sformatf("tbl[%0d].IFF2", i), IFF2, vecs[i].expIff2);
            check($sformatf("tbl[%0d].IM", i), IM, vecs[i].expIm);
            clearInputs();
        end

        // NMI sequence and RETN restore
        OpEI = 1; step(); OpEI = 0;
        NMI = 1; step();
        check("nmi.TNMI", TNMI, 1);
        step();
        InstrEnd = 1; step();
        check("nmi.ackBusy", Busy, 1);
        check("nmi.ackClr", {TNMI, IFF1, IFF2}, 3'b001);
        InstrEnd = 0; NMI = 0; step();
        check("nmi.push1", PushReq, 1);
        step();
        check("nmi.push2", PushReq, 1);
        PushDone = 1; step(); PushDone = 0;
        check("nmi.jump", {JumpValid, PushReq}, 2'b10);
        check("nmi.addr", JumpAddr, 16'h0066);
        step();
        check("nmi.idle", {Busy, JumpValid}, 0);
        check("nmi.iff", {IFF1, IFF2}, 2'b01);
        OpRETN = 1; step(); OpRETN = 0;
        check("nmi.retn", IFF1, 1);

        // IM2: EI blocks INT at its own boundary, next boundary accepted
        OpIM = 1; ImVal = 2'b11; step(); OpIM = 0;
        IReg = 8'h80; DataBus = 8'h35;
        OpEI = 1; INT = 1; InstrEnd = 1; step(); OpEI = 0;
        check("im2.eiBlock", Busy, 0);
        step();
        check("im2.ack1", IntAck, 1);
        check("im2.iff", {IFF1, IFF2}, 0);
        InstrEnd = 0; step();
        check("im2.ack2", IntAck, 1);
        INT = 0; step();
        check("im2.push", {IntAck, PushReq}, 2'b01);
        PushDone = 1; step(); PushDone = 0;
        check("im2.vrd", VecRdReq, 1);
        check("im2.vaddr", VecRdAddr, 16'h8034);
        VecRdData = 16'h1234; VecRdDone = 1; step(); VecRdDone = 0;
        check("im2.jump", JumpValid, 1);
        check("im2.jaddr", JumpAddr, 16'h1234);
        step();
        check("im2.idle", Busy, 0);

        // IM1: NMI beats INT; INT then masked
        OpIM = 1; ImVal = 2'b10; OpEI = 1; step(); OpIM = 0; OpEI = 0;
        NMI = 1; INT = 1; step();
        check("pri.TNMI", {TNMI, Busy}, 2'b10);
        InstrEnd = 1; step();
        check("pri.nmiAck", {Busy, IntAck, TNMI, IFF1}, 4'b1000);
        InstrEnd = 0; step();
        PushDone = 1; step(); PushDone = 0;
        check("pri.jaddr", {JumpValid, JumpAddr}, {1'b1, 16'h0066});
        InstrEnd = 1; step();
        check("pri.idle", Busy, 0);
        step();
        check("pri.masked", {Busy, IntAck}, 0);
        clearInputs();

        // IM0 injection
        OpIM = 1; ImVal = 2'b00; OpEI = 1; step(); OpIM = 0; OpEI = 0;
        INT = 1; InstrEnd = 1; DataBus = 8'hFF; step();
        check("im0.ack", IntAck, 1);
        INT = 0; InstrEnd = 0; step(); step();
        check("im0.inj", {InjectValid, PushReq}, 2'b10);
        check("im0.op", InjectOp, 8'hFF);
        step();
        check("im0.idle", {Busy, InjectValid, PushReq}, 0);
        clearInputs();

        // NMI arriving during the push of an IM1 INT
        OpIM = 1; ImVal = 2'b10; OpEI = 1; step(); OpIM = 0; OpEI = 0;
        INT = 1; InstrEnd = 1; step();
        INT = 0; InstrEnd = 0; step(); step();
        check("late.push", PushReq, 1);
        NMI = 1; step();
        check("late.tnmi", {TNMI, PushReq}, 2'b11);
        PushDone = 1; step(); PushDone = 0;
        check("late.jump", {JumpValid, JumpAddr, TNMI}, {1'b1, 16'h0038, 1'b1});
        step();
        check("late.idle", {Busy, TNMI}, 2'b01);
        step();
        check("late.wait", {Busy, TNMI}, 2'b01);
        InstrEnd = 1; step(); InstrEnd = 0; NMI = 0;
        check("late.nmiAck", {Busy, TNMI, IntAck}, 3'b100);
        step(); PushDone = 1; step(); PushDone = 0;
        check("late.nmiJump", {JumpValid, JumpAddr}, {1'b1, 16'h0066});
        step();

        // Reset in the middle of VEC_RD
        OpIM = 1; ImVal = 2'b11; OpEI = 1; step(); OpIM = 0; OpEI = 0;
        IReg = 8'h12; DataBus = 8'h0F; INT = 1; InstrEnd = 1; step();
        INT = 0; InstrEnd = 0; step(); step();
        PushDone = 1; step(); PushDone = 0;
        check("rvr.vrd", {VecRdReq, VecRdAddr}, {1'b1, 16'h120E});
        #2 Reset = 1;
        #1;
        check("rvr.outs", {Busy, IntAck, PushReq, VecRdReq, JumpValid, InjectValid}, 0);
        check("rvr.state", {TNMI, IFF1, IFF2, IM}, 0);
        check("rvr.data", {VecRdAddr, JumpAddr, InjectOp}, 0);
        step();
        Reset = 0; VecRdDone = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rvr.noJump", {JumpValid, Busy}, 0);
        end
        clearInputs();

        // randomized traffic against the model
        Reset = 1; step(); Reset = 0;
        modelReset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            modelCompare();
            r = $urandom_range(0, 19);
            OpEI = (r == 0) || (r == 1);
            OpDI = (r == 2);
            OpRETN = (r == 3);
            OpIM = ($urandom_range(0, 9) == 0);
            ImVal = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) NMI = ~NMI;
            INT = ($urandom_range(0, 9) < 6);
            InstrEnd = ($urandom_range(0, 9) < 4);
            IReg = 8'($urandom);
            DataBus = 8'($urandom);
            PushDone = $urandom_range(0, 1);
            VecRdDone = $urandom_range(0, 1);
            VecRdData = 16'($urandom);
            modelStep();
            step();
        end
        modelCompare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
